pending_encoder: RTL and testbench

//  Inverse of the 3-to-8 one-hot decoder. Latches an 8-bit request word, then emits
//  the 3-bit index of each set bit, one per handshake, in fixed priority order.
//  Bit 0 (MSB-first vector [0:7]) goes first, so Idx values round-trip through the decoder.

---
 rtl/pending_encoder_pkg.sv | 22 ++
 rtl/pending_encoder_pri_enc8to3.sv | 21 ++
 rtl/pending_encoder.sv | 89 ++++++++
 tb/tb_pending_encoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pending_encoder_pkg.sv
// Shared state encodings, widths and load-time popcount for the pending-index encoder.
package pending_encoder_pkg;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StEmit = 1'b1
  } state_e;

  function automatic logic [CW-1:0] popcount8(input logic [0:N-1] vec);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      cnt = cnt + {{(CW-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pending_encoder_pri_enc8to3.sv
// Find-first-set over an MSB-first [0:7] vector: lowest-numbered set bit wins.
module pending_encoder_pri_enc8to3
  import pending_encoder_pkg::*;
(
  input  logic [0:N-1]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    // Walk downwards so the lowest-numbered set bit is the last to write idx_o.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/pending_encoder.sv
// Latches a request mask and emits the index of each set bit, one per handshake,
// lowest-numbered bit first; pulses done once the last index is accepted.
module pending_encoder
  import pending_encoder_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [0:N-1]  req_i,
  input  logic          req_load_i,
  input  logic          ready_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o,
  output logic          busy_o,
  output logic [CW-1:0] count_o,
  output logic          done_o
);

  state_e        state_q, state_d;
  logic [0:N-1]  pend_q, pend_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic [IW-1:0] ffs_idx;
  logic          ffs_any;

  // Encode the next pending mask so idx is a plain register output.
  pending_encoder_pri_enc8to3 u_pri_enc (
    .vec_i (pend_d),
    .idx_o (ffs_idx),
    .any_o (ffs_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pend_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    count_d = count_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_load_i) begin
          if (|req_i) begin
            pend_d  = req_i;
            count_d = popcount8(req_i);
            state_d = StEmit;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StEmit: begin
        if (ready_i) begin
          pend_d[idx_q] = 1'b0;
          count_d       = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    idx_d = ffs_any ? ffs_idx : '0;
  end

  always_comb begin
    valid_o = (state_q == StEmit);
    busy_o  = (state_q == StEmit);
    idx_o   = idx_q;
    count_o = count_q;
    done_o  = done_q;
  end

endmodule

// File: tb/tb_pending_encoder.sv
// Directed bench for pending_encoder: reset, sparse, backpressure, empty, busy-load, round trip.
module tb_pending_encoder;

  logic       clk;
  logic       rst_n;
  logic [0:7] req;
  logic       req_load;
  logic       ready;
  logic [2:0] idx;
  logic       valid;
  logic       busy;
  logic [3:0] count;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;

  pending_encoder dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .req_load_i (req_load),
    .ready_i    (ready),
    .idx_o      (idx),
    .valid_o    (valid),
    .busy_o     (busy),
    .count_o    (count),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:7] dec3to8(input logic [2:0] a, input logic en);
    logic [0:7] o;
    o = '0;
    if (en) o[a] = 1'b1;
    return o;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_load = 1'b0; ready = 1'b0;
    #3;
    n_total++;
    if ({idx, valid, busy, count, done} !== 10'd0) begin
      $display("FAIL reset_init: idx=%0d valid=%b busy=%b count=%0d done=%b, want all 0",
               idx, valid, busy, count, done);
    end else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // Load, stall, then reset asynchronously mid-EMIT.
    req = 8'b1010_0000; req_load = 1'b1;
    tick();
    req_load = 1'b0;
    n_total++;
    if (valid !== 1'b1 || idx !== 3'd0 || count !== 4'd2 || busy !== 1'b1) begin
      $display("FAIL reset_load: idx=%0d valid=%b count=%0d busy=%b, want idx=0 valid=1 count=2 busy=1",
               idx, valid, count, busy);
    end else n_pass++;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({idx, valid, busy, count, done} !== 10'd0) begin
      $display("FAIL reset_mid_emit: idx=%0d valid=%b busy=%b count=%0d done=%b, want all 0",
               idx, valid, busy, count, done);
    end else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_total++;
    if ({idx, valid, busy, count, done} !== 10'd0) begin
      $display("FAIL reset_after: idx=%0d valid=%b busy=%b count=%0d done=%b, want all 0",
               idx, valid, busy, count, done);
    end else n_pass++;
    // Fresh load after reset: indices 0 then 2 then done.
    req = 8'b1010_0000; req_load = 1'b1; ready = 1'b1;
    tick();
    req_load = 1'b0;
    n_total++;
    if (valid !== 1'b1 || idx !== 3'd0 || count !== 4'd2) begin
      $display("FAIL reset_fresh0: idx=%0d valid=%b count=%0d, want idx=0 valid=1 count=2",
               idx, valid, count);
    end else n_pass++;
    tick();
    n_total++;
    if (valid !== 1'b1 || idx !== 3'd2 || count !== 4'd1) begin
      $display("FAIL reset_fresh1: idx=%0d valid=%b count=%0d, want idx=2 valid=1 count=1",
               idx, valid, count);
    end else n_pass++;
    tick();
    n_total++;
    if (valid !== 1'b0 || done !== 1'b1 || count !== 4'd0 || idx !== 3'd0) begin
      $display("FAIL reset_fresh_done: valid=%b done=%b count=%0d idx=%0d, want 0 1 0 0",
               valid, done, count, idx);
    end else n_pass++;
    ready = 1'b0;
    tick();
  endtask

  task automatic test_sparse();
    logic [2:0] e_idx [3];
    logic [3:0] e_cnt [3];
    e_idx = '{3'd1, 3'd5, 3'd7};
    e_cnt = '{4'd3, 4'd2, 4'd1};
    req = 8'b0100_0101; req_load = 1'b1; ready = 1'b1;
    tick();
    req_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (valid !== 1'b1 || idx !== e_idx[i] || count !== e_cnt[i] || done !== 1'b0) begin
        $display("FAIL sparse[%0d]: idx=%0d valid=%b count=%0d done=%b, want idx=%0d valid=1 count=%0d done=0",
                 i, idx, valid, count, done, e_idx[i], e_cnt[i]);
      end else n_pass++;
      tick();
    end
    n_total++;
    if (valid !== 1'b0 || done !== 1'b1 || count !== 4'd0 || idx !== 3'd0 || busy !== 1'b0) begin
      $display("FAIL sparse_done: valid=%b done=%b count=%0d idx=%0d busy=%b, want 0 1 0 0 0",
               valid, done, count, idx, busy);
    end else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0) begin
      $display("FAIL sparse_done_pulse: done=%b, want 0", done);
    end else n_pass++;
    ready = 1'b0;
  endtask

  task automatic test_backpressure();
    req = 8'b1000_0001; req_load = 1'b1; ready = 1'b0;
    tick();
    req_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (valid !== 1'b1 || idx !== 3'd0 || count !== 4'd2) begin
        $display("FAIL bp_hold[%0d]: idx=%0d valid=%b count=%0d, want idx=0 valid=1 count=2",
                 i, idx, valid, count);
      end else n_pass++;
      tick();
    end
    ready = 1'b1;
    n_total++;
    if (valid !== 1'b1 || idx !== 3'd0) begin
      $display("FAIL bp_before_accept: idx=%0d valid=%b, want idx=0 valid=1", idx, valid);
    end else n_pass++;
    tick();
    n_total++;
    if (valid !== 1'b1 || idx !== 3'd7 || count !== 4'd1) begin
      $display("FAIL bp_second: idx=%0d valid=%b count=%0d, want idx=7 valid=1 count=1",
               idx, valid, count);
    end else n_pass++;
    tick();
    n_total++;
    if (valid !== 1'b0 || done !== 1'b1 || count !== 4'd0) begin
      $display("FAIL bp_done: valid=%b done=%b count=%0d, want 0 1 0", valid, done, count);
    end else n_pass++;
    ready = 1'b0;
    tick();
  endtask

  task automatic test_empty_load();
    req = 8'h00; req_load = 1'b1; ready = 1'b1;
    tick();
    req_load = 1'b0;
    n_total++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || count !== 4'd0) begin
      $display("FAIL empty_done: done=%b valid=%b busy=%b count=%0d, want 1 0 0 0",
               done, valid, busy, count);
    end else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL empty_after: done=%b valid=%b busy=%b, want 0 0 0", done, valid, busy);
    end else n_pass++;
    ready = 1'b0;
  endtask

  task automatic test_load_while_busy();
    req = 8'h80; req_load = 1'b1; ready = 1'b0;
    tick();
    req = 8'hFF;
    tick();
    n_total++;
    if (valid !== 1'b1 || idx !== 3'd0 || count !== 4'd1 || busy !== 1'b1) begin
      $display("FAIL busy_ignore: idx=%0d valid=%b count=%0d busy=%b, want idx=0 valid=1 count=1 busy=1",
               idx, valid, count, busy);
    end else n_pass++;
    // Final accept with a load held high: the load must be ignored.
    ready = 1'b1;
    tick();
    n_total++;
    if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || count !== 4'd0) begin
      $display("FAIL busy_final: valid=%b done=%b busy=%b count=%0d, want 0 1 0 0",
               valid, done, busy, count);
    end else n_pass++;
    // Same load still asserted while done is high in IDLE: accepted.
    tick();
    req_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (valid !== 1'b1 || idx !== 3'(i) || count !== 4'(8 - i) || busy !== 1'b1) begin
        $display("FAIL busy_ff[%0d]: idx=%0d valid=%b count=%0d busy=%b, want idx=%0d valid=1 count=%0d busy=1",
                 i, idx, valid, count, busy, i, 8 - i);
      end else n_pass++;
      tick();
    end
    n_total++;
    if (valid !== 1'b0 || done !== 1'b1 || count !== 4'd0) begin
      $display("FAIL busy_ff_done: valid=%b done=%b count=%0d, want 0 1 0", valid, done, count);
    end else n_pass++;
    ready = 1'b0;
    tick();
  endtask

  task automatic test_round_trip();
    logic [0:7] acc;
    logic [0:7] mask;
    int         cycles;
    int         bad;
    bad = 0;
    for (int m = 0; m < 256; m++) begin
      mask = 8'(m);
      req = mask; req_load = 1'b1; ready = 1'b1;
      tick();
      req_load = 1'b0;
      acc = '0;
      cycles = 0;
      while (done !== 1'b1 && cycles < 20) begin
        if (valid === 1'b1) acc = acc | dec3to8(idx, 1'b1);
        tick();
        cycles++;
      end
      n_total++;
      if (done !== 1'b1 || acc !== mask) begin
        if (bad < 8) begin
          $display("FAIL round_trip[%0d]: ored=%b done=%b after %0d cycles, want ored=%b done=1",
                   m, acc, done, cycles, mask);
        end
        bad++;
      end else n_pass++;
      tick();
    end
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_backpressure();
    test_empty_load();
    test_load_while_busy();
    test_round_trip();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
